// File: rtl/usb_speed_ctrl_pkg.sv
// Shared USB speed encodings and helpers for the speed-detect sequencer.
package usb_speed_ctrl_pkg;

  localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
  localparam logic [1:0] USB_SPEED_LS   = 2'd1;
  localparam logic [1:0] USB_SPEED_FS   = 2'd2;
  localparam logic [1:0] USB_SPEED_HS   = 2'd3;

  function automatic logic is_speed(input logic [1:0] spd);
    return spd != USB_SPEED_AUTO;
  endfunction

endpackage

// File: rtl/usb_speed_ctrl.sv
// Speed autodetect sequencer: restart pulse, bounded-retry wait for a result,
// debounce, and publication of a locked (or forced) speed.
module usb_speed_ctrl
  import usb_speed_ctrl_pkg::*;
#(
  parameter int unsigned pRESTART_CYCLES = 32'd10,
  parameter int unsigned pTIMEOUT_WIDTH  = 32'd21,
  parameter int unsigned pTIMEOUT_CYCLES = 32'd1048576,
  parameter int unsigned pSTABLE_CYCLES  = 32'd4,
  parameter int unsigned pMAX_RETRIES    = 32'd3
) (
  input  logic       cwusb_clk,
  input  logic       reset_i,
  input  logic [1:0] I_mode,
  input  logic       I_start,
  input  logic       I_stop,
  input  logic [1:0] I_detect_speed,
  output logic       O_restart,
  output logic [1:0] O_speed,
  output logic       O_locked,
  output logic       O_busy,
  output logic       O_fail,
  output logic       O_lost,
  output logic [3:0] O_retries
);

  localparam int RC_W = $clog2(pRESTART_CYCLES + 32'd1);
  localparam int ST_W = $clog2(pSTABLE_CYCLES + 32'd1);
  localparam int TM_W = pTIMEOUT_WIDTH;

  localparam logic [RC_W-1:0] RC_ONE    = RC_W'(1'b1);
  localparam logic [RC_W-1:0] RC_FULL   = RC_W'(pRESTART_CYCLES);
  localparam logic [ST_W-1:0] ST_ZERO   = ST_W'(1'b0);
  localparam logic [ST_W-1:0] ST_ONE    = ST_W'(1'b1);
  localparam logic [ST_W-1:0] ST_FULL   = ST_W'(pSTABLE_CYCLES);
  localparam logic [ST_W-1:0] ST_LAST   = ST_W'(pSTABLE_CYCLES - 32'd1);
  localparam logic [TM_W-1:0] TM_ZERO   = TM_W'(1'b0);
  localparam logic [TM_W-1:0] TM_ONE    = TM_W'(1'b1);
  localparam logic [TM_W-1:0] TM_LAST   = TM_W'(pTIMEOUT_CYCLES - 32'd1);
  localparam logic [TM_W-1:0] TM_MAX    = {TM_W{1'b1}};
  localparam logic [3:0]      RETRY_MAX = 4'(pMAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CONFIRM = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  state_t          state_r;
  logic [RC_W-1:0] restart_cnt_r;
  logic [TM_W-1:0] tmo_r;
  logic [ST_W-1:0] stable_r;
  logic [ST_W-1:0] lost_cnt_r;
  logic [1:0]      cand_r;
  logic            forced_r;

  logic            match_s;
  logic            lock_hit_s;
  logic            timeout_s;
  logic [TM_W-1:0] tmo_inc_s;

  // Lock/timeout arbitration; a lock completing on the timeout cycle wins.
  always_comb begin
    match_s    = (I_detect_speed == cand_r);
    tmo_inc_s  = (tmo_r != TM_MAX) ? (tmo_r + TM_ONE) : tmo_r;
    lock_hit_s = 1'b0;
    if (state_r == ST_CONFIRM) begin
      lock_hit_s = (stable_r == ST_FULL) || (match_s && (stable_r == ST_LAST));
    end else begin
      lock_hit_s = 1'b0;
    end
    timeout_s = ((state_r == ST_WAIT) || (state_r == ST_CONFIRM)) &&
                (tmo_r >= TM_LAST) && !lock_hit_s;
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      state_r       <= ST_IDLE;
      restart_cnt_r <= '0;
      tmo_r         <= '0;
      stable_r      <= '0;
      lost_cnt_r    <= '0;
      cand_r        <= USB_SPEED_AUTO;
      forced_r      <= 1'b0;
      O_restart     <= 1'b0;
      O_speed       <= USB_SPEED_AUTO;
      O_locked      <= 1'b0;
      O_busy        <= 1'b0;
      O_fail        <= 1'b0;
      O_lost        <= 1'b0;
      O_retries     <= 4'd0;
    end else if (I_stop) begin
      state_r    <= ST_IDLE;
      O_restart  <= 1'b0;
      O_speed    <= USB_SPEED_AUTO;
      O_locked   <= 1'b0;
      O_busy     <= 1'b0;
      O_fail     <= 1'b0;
      O_lost     <= 1'b0;
      O_retries  <= 4'd0;
      forced_r   <= 1'b0;
      lost_cnt_r <= ST_ZERO;
    end else if (I_start) begin
      O_fail     <= 1'b0;
      O_lost     <= 1'b0;
      O_retries  <= 4'd0;
      lost_cnt_r <= ST_ZERO;
      if (is_speed(I_mode)) begin
        state_r   <= ST_LOCKED;
        forced_r  <= 1'b1;
        O_speed   <= I_mode;
        O_locked  <= 1'b1;
        O_restart <= 1'b0;
        O_busy    <= 1'b0;
      end else begin
        state_r       <= ST_RESTART;
        forced_r      <= 1'b0;
        O_speed       <= USB_SPEED_AUTO;
        O_locked      <= 1'b0;
        O_restart     <= 1'b1;
        O_busy        <= 1'b1;
        restart_cnt_r <= RC_ONE;
        tmo_r         <= TM_ZERO;
      end
    end else if (timeout_s) begin
      if (O_retries < RETRY_MAX) begin
        O_retries     <= O_retries + 4'd1;
        state_r       <= ST_RESTART;
        O_restart     <= 1'b1;
        restart_cnt_r <= RC_ONE;
        tmo_r         <= TM_ZERO;
      end else begin
        state_r <= ST_FAIL;
        O_fail  <= 1'b1;
        O_speed <= USB_SPEED_AUTO;
        O_busy  <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_RESTART: begin
          if (restart_cnt_r >= RC_FULL) begin
            state_r   <= ST_WAIT;
            O_restart <= 1'b0;
          end else begin
            restart_cnt_r <= restart_cnt_r + RC_ONE;
          end
        end
        ST_WAIT: begin
          tmo_r <= tmo_inc_s;
          if (is_speed(I_detect_speed)) begin
            cand_r   <= I_detect_speed;
            stable_r <= ST_ONE;
            state_r  <= ST_CONFIRM;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_CONFIRM: begin
          tmo_r <= tmo_inc_s;
          if (lock_hit_s && (stable_r == ST_FULL)) begin
            state_r    <= ST_LOCKED;
            O_speed    <= cand_r;
            O_locked   <= 1'b1;
            O_busy     <= 1'b0;
            lost_cnt_r <= ST_ZERO;
          end else if (lock_hit_s) begin
            stable_r <= ST_FULL;
          end else if (match_s) begin
            stable_r <= stable_r + ST_ONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_LOCKED: begin
          // A forced lock never watches the detector.
          if (!forced_r && (I_detect_speed != O_speed)) begin
            if (lost_cnt_r >= ST_LAST) begin
              O_lost <= 1'b1;
            end else begin
              lost_cnt_r <= lost_cnt_r + ST_ONE;
            end
          end else begin
            lost_cnt_r <= ST_ZERO;
          end
        end
        ST_IDLE, ST_FAIL: begin
          state_r <= state_r;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_speed_ctrl.sv
// Randomized bench for usb_speed_ctrl: detector traces are generated up front and
// the expected lock time/speed/retries are derived from attempt windows in the trace.
module tb_usb_speed_ctrl;
  import usb_speed_ctrl_pkg::*;

  localparam int NT      = 320;
  localparam int RST_CYC = 10;
  localparam int TMO     = 64;
  localparam int STABLE  = 4;
  localparam int RETRIES = 2;

  logic       cwusb_clk = 1'b0;
  logic       reset_i;
  logic [1:0] I_mode;
  logic       I_start;
  logic       I_stop;
  logic [1:0] I_detect_speed;
  logic       O_restart;
  logic [1:0] O_speed;
  logic       O_locked;
  logic       O_busy;
  logic       O_fail;
  logic       O_lost;
  logic [3:0] O_retries;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] trace [0:NT];

  usb_speed_ctrl #(
    .pRESTART_CYCLES(RST_CYC), .pTIMEOUT_WIDTH(8), .pTIMEOUT_CYCLES(TMO),
    .pSTABLE_CYCLES(STABLE), .pMAX_RETRIES(RETRIES)
  ) dut (
    .cwusb_clk(cwusb_clk), .reset_i(reset_i), .I_mode(I_mode), .I_start(I_start),
    .I_stop(I_stop), .I_detect_speed(I_detect_speed), .O_restart(O_restart),
    .O_speed(O_speed), .O_locked(O_locked), .O_busy(O_busy), .O_fail(O_fail),
    .O_lost(O_lost), .O_retries(O_retries)
  );

  always #5 cwusb_clk = ~cwusb_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cwusb_clk);
    #1;
  endtask

  task automatic build_trace(input bit no_lock, input bit force_fs);
    int pre, idx, glen, gap;
    logic [1:0] fin, gsp;
    for (int i = 0; i <= NT; i++) trace[i] = USB_SPEED_AUTO;
    if (!no_lock) begin
      pre = force_fs ? 5 : int'($urandom_range(0, 140));
      fin = force_fs ? USB_SPEED_FS : 2'($urandom_range(1, 3));
      idx = pre;
      if (!force_fs && ($urandom_range(0, 1) == 1)) begin
        glen = int'($urandom_range(1, 3));
        gap  = int'($urandom_range(1, 3));
        gsp  = 2'($urandom_range(1, 3));
        for (int j = 0; j < glen; j++) trace[idx + j] = gsp;
        idx = idx + glen + gap;
      end
      for (int i = idx; i <= NT; i++) trace[i] = fin;
    end
  endtask

  // Each attempt starts with a restart edge s; detector samples count on edges s+11..s+74.
  task automatic run_auto_trial(input string tag, input bit no_lock, input bit force_fs);
    int s, exp_lock, exp_att, rcount, seen_lock;
    logic [1:0] exp_spd;
    bit found;
    build_trace(no_lock, force_fs);
    s = 0; exp_lock = -1; exp_att = RETRIES + 1; exp_spd = USB_SPEED_AUTO; found = 1'b0;
    for (int k = 0; k <= RETRIES && !found; k++) begin
      for (int a = s + RST_CYC + 1; a + STABLE - 1 <= s + RST_CYC + TMO && !found; a++) begin
        if (trace[a] != USB_SPEED_AUTO && trace[a+1] == trace[a] &&
            trace[a+2] == trace[a] && trace[a+3] == trace[a]) begin
          found = 1'b1; exp_lock = a + STABLE; exp_spd = trace[a]; exp_att = k + 1;
        end
      end
      s = s + RST_CYC + TMO;
    end
    rcount = 0; seen_lock = -1;
    I_mode = USB_SPEED_AUTO; I_start = 1'b1; I_detect_speed = trace[0];
    tick();
    I_start = 1'b0;
    if (O_restart) rcount++;
    for (int e = 1; e <= NT; e++) begin
      I_detect_speed = trace[e];
      tick();
      if (O_restart) rcount++;
      if (O_locked && seen_lock < 0) seen_lock = e;
    end
    check({tag, "_restart_cycles"}, rcount, RST_CYC * exp_att);
    check({tag, "_lock_edge"}, seen_lock, exp_lock);
    check({tag, "_speed"}, int'(O_speed), int'(exp_spd));
    check({tag, "_retries"}, int'(O_retries), exp_att - 1);
    check({tag, "_fail"}, int'(O_fail), found ? 0 : 1);
    check({tag, "_busy"}, int'(O_busy), 0);
  endtask

  initial begin
    int rhigh;
    reset_i = 1'b1; I_mode = USB_SPEED_AUTO; I_start = 1'b0; I_stop = 1'b0;
    I_detect_speed = USB_SPEED_AUTO;
    tick(); tick();
    check("rst_restart", int'(O_restart), 0);
    check("rst_speed", int'(O_speed), int'(USB_SPEED_AUTO));
    check("rst_locked", int'(O_locked), 0);
    check("rst_busy", int'(O_busy), 0);
    check("rst_retries", int'(O_retries), 0);
    reset_i = 1'b0;
    tick();

    // Forced speed: locks one edge after start, never restarts, ignores detector.
    I_mode = USB_SPEED_FS; I_start = 1'b1;
    tick();
    I_start = 1'b0;
    check("forced_locked", int'(O_locked), 1);
    check("forced_speed", int'(O_speed), int'(USB_SPEED_FS));
    rhigh = int'(O_restart);
    I_detect_speed = USB_SPEED_HS;
    for (int i = 0; i < 8; i++) begin
      tick();
      rhigh = rhigh | int'(O_restart);
    end
    check("forced_no_restart", rhigh, 0);
    check("forced_no_lost", int'(O_lost), 0);

    run_auto_trial("fail", 1'b1, 1'b0);
    I_mode = USB_SPEED_AUTO; I_start = 1'b1; I_detect_speed = USB_SPEED_AUTO;
    tick();
    I_start = 1'b0;
    check("restart_clears_fail", int'(O_fail), 0);
    check("restart_busy", int'(O_busy), 1);

    for (int t = 0; t < 8; t++) run_auto_trial($sformatf("rnd%0d", t), 1'b0, 1'b0);

    // Lost: departure from a locked FS for STABLE cycles.
    run_auto_trial("lockfs", 1'b0, 1'b1);
    I_detect_speed = USB_SPEED_HS;
    for (int i = 0; i < STABLE - 1; i++) tick();
    check("lost_early", int'(O_lost), 0);
    tick();
    check("lost_set", int'(O_lost), 1);
    check("lost_speed_held", int'(O_speed), int'(USB_SPEED_FS));
    check("lost_locked_held", int'(O_locked), 1);

    // Start mid-WAIT restarts the pulse; stop mid-RESTART drops it next edge.
    I_detect_speed = USB_SPEED_AUTO; I_mode = USB_SPEED_AUTO; I_start = 1'b1;
    tick();
    I_start = 1'b0;
    check("start_clears_lost", int'(O_lost), 0);
    for (int i = 0; i < 12; i++) tick();
    check("in_wait_restart", int'(O_restart), 0);
    check("in_wait_busy", int'(O_busy), 1);
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    check("rewait_restart", int'(O_restart), 1);
    tick(); tick();
    I_stop = 1'b1; I_start = 1'b1;
    tick();
    I_stop = 1'b0; I_start = 1'b0;
    check("stop_restart", int'(O_restart), 0);
    check("stop_busy", int'(O_busy), 0);
    check("stop_speed", int'(O_speed), int'(USB_SPEED_AUTO));

    // Asynchronous reset mid-RESTART drops the restart line without a clock edge.
    I_start = 1'b1;
    tick();
    I_start = 1'b0;
    tick();
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_restart", int'(O_restart), 0);
    check("async_rst_busy", int'(O_busy), 0);
    reset_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
